// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: hands the game work-RAM port to the hiscore engine.
// Requests a CPU pause, waits for ack + settle, grants, then drains.
//
// Ports:
//   clk_sys, reset         clock, async active-high reset
//   hs_intent_rd/_wr       hiscore engine wants the port (level)
//   hs_strobe/we/addr/wdata one byte access, honoured while granted
//   hs_rdata/hs_rvalid     read return, two cycles after the strobe
//   hs_grant               port owned by the hiscore engine
//   hs_fail                one-cycle pulse when the pause times out
//   pause_req/cpu_paused   handshake with the pause system
//   ram_sel/addr/din/we    registered drive into the core's RAM mux
//   ram_dout               synchronous RAM read data (1-cycle latency)
module hs_ram_arbiter #(
   parameter int AW      = 12,
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          hs_intent_rd,
   input  logic          hs_intent_wr,
   input  logic          hs_strobe,
   input  logic          hs_we,
   input  logic [AW-1:0] hs_addr,
   input  logic [7:0]    hs_wdata,
   output logic [7:0]    hs_rdata,
   output logic          hs_rvalid,
   output logic          hs_grant,
   output logic          hs_fail,
   output logic          pause_req,
   input  logic          cpu_paused,
   output logic          ram_sel,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   input  logic [7:0]    ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PWAIT,
      S_SETTLE,
      S_GRANT,
      S_DRAIN
   } state_t;

   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT);

   state_t        state_q, state_d;
   logic [15:0]   tmo_q, tmo_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          pause_req_q, pause_req_d;
   logic          ram_sel_q, ram_sel_d;
   logic          hs_grant_q, hs_grant_d;
   logic          hs_fail_q, hs_fail_d;
   logic          ram_we_q, ram_we_d;
   logic          rd_issue_q, rd_issue_d;
   logic          hs_rvalid_q, hs_rvalid_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]    ram_din_q, ram_din_d;

   logic intent;
   logic accept;

   assign intent = hs_intent_rd | hs_intent_wr;

   // A strobe that coincides with the intent drop is not taken.
   assign accept = (state_q == S_GRANT) & intent & hs_strobe;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         S_IDLE: begin
            tmo_d  = '0;
            wcnt_d = '0;
            if (intent) state_d = S_PWAIT;
         end
         S_PWAIT: begin
            tmo_d  = tmo_q + 16'd1;
            wcnt_d = '0;
            if (tmo_q == TMO_LIMIT || !intent)
               state_d = S_IDLE;
            else if (cpu_paused)
               state_d = S_SETTLE;
         end
         S_SETTLE: begin
            // Timeout count is held so a pause bounce
            // keeps counting toward the same limit.
            wcnt_d = wcnt_q + 4'd1;
            if (!intent) begin
               state_d = S_IDLE;
            end else if (!cpu_paused) begin
               state_d = S_PWAIT;
            end else if (wcnt_q == SETTLE_LAST) begin
               state_d = S_GRANT;
               wcnt_d  = '0;
            end
         end
         S_GRANT: begin
            wcnt_d = '0;
            if (!intent) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Two cycles let the last read return.
            wcnt_d = wcnt_q + 4'd1;
            if (wcnt_q == 4'd1) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      pause_req_d = (state_d != S_IDLE);
      ram_sel_d   = (state_d == S_SETTLE) |
                    (state_d == S_GRANT)  |
                    (state_d == S_DRAIN);
      hs_grant_d  = (state_d == S_GRANT);
      // Pulses in the cycle the counter hits the limit.
      hs_fail_d   = (state_d == S_PWAIT) &
                    (tmo_d == TMO_LIMIT);
      ram_we_d    = accept & hs_we;
      rd_issue_d  = accept & ~hs_we;
      hs_rvalid_d = rd_issue_q;
      ram_addr_d  = accept ? hs_addr  : ram_addr_q;
      ram_din_d   = accept ? hs_wdata : ram_din_q;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tmo_q       <= '0;
         wcnt_q      <= '0;
         pause_req_q <= 1'b0;
         ram_sel_q   <= 1'b0;
         hs_grant_q  <= 1'b0;
         hs_fail_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         rd_issue_q  <= 1'b0;
         hs_rvalid_q <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         wcnt_q      <= wcnt_d;
         pause_req_q <= pause_req_d;
         ram_sel_q   <= ram_sel_d;
         hs_grant_q  <= hs_grant_d;
         hs_fail_q   <= hs_fail_d;
         ram_we_q    <= ram_we_d;
         rd_issue_q  <= rd_issue_d;
         hs_rvalid_q <= hs_rvalid_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
      end
   end

   assign pause_req = pause_req_q;
   assign ram_sel   = ram_sel_q;
   assign hs_grant  = hs_grant_q;
   assign hs_fail   = hs_fail_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign hs_rvalid = hs_rvalid_q;

   // RAM data arrives the cycle rvalid is high; it is
   // forced to zero otherwise so reset leaves it clean.
   assign hs_rdata = hs_rvalid_q ? ram_dout : 8'h00;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb_hs_ram_arbiter: directed vector table plus hand-written
// sequences for timeout and asynchronous reset.
module tb_hs_ram_arbiter;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        hs_intent_rd, hs_intent_wr;
   logic        hs_strobe, hs_we;
   logic [11:0] hs_addr;
   logic [7:0]  hs_wdata;
   logic [7:0]  hs_rdata;
   logic        hs_rvalid, hs_grant, hs_fail;
   logic        pause_req, cpu_paused;
   logic        ram_sel, ram_we;
   logic [11:0] ram_addr;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;

   int n_chk = 0;
   int n_err = 0;

   hs_ram_arbiter #(.AW(12), .SETTLE(4), .TIMEOUT(20)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .hs_intent_rd (hs_intent_rd),
      .hs_intent_wr (hs_intent_wr),
      .hs_strobe    (hs_strobe),
      .hs_we        (hs_we),
      .hs_addr      (hs_addr),
      .hs_wdata     (hs_wdata),
      .hs_rdata     (hs_rdata),
      .hs_rvalid    (hs_rvalid),
      .hs_grant     (hs_grant),
      .hs_fail      (hs_fail),
      .pause_req    (pause_req),
      .cpu_paused   (cpu_paused),
      .ram_sel      (ram_sel),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_we       (ram_we),
      .ram_dout     (ram_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Synchronous RAM model: data = addr + 0x10, one cycle latency.
   always_ff @(posedge clk_sys) ram_dout <= ram_addr[7:0] + 8'h10;

   // in_f = {rd, wr, strobe, we, cpu_paused}
   // ef   = {pause_req, ram_sel, grant, fail, ram_we, rvalid}
   typedef struct {
      logic [4:0]  in_f;
      logic [11:0] addr;
      logic [7:0]  wdata;
      logic [5:0]  ef;
      logic [7:0]  rdata;
      logic [11:0] raddr;
      logic [7:0]  rdin;
   } vec_t;

   vec_t tv[$];

   task automatic v(input logic [4:0] i, input logic [11:0] a,
                    input logic [7:0] w, input logic [5:0] e,
                    input logic [7:0] rd, input logic [11:0] ra,
                    input logic [7:0] rw);
      vec_t t;
      t.in_f = i; t.addr = a; t.wdata = w; t.ef = e;
      t.rdata = rd; t.raddr = ra; t.rdin = rw;
      tv.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {30'd0, hs_rdata, hs_rvalid, hs_grant, hs_fail,
              pause_req, ram_sel, ram_addr, ram_din, ram_we};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rise, failc, nfail, gseen, n;
      logic preq_after;

      reset = 1'b1;
      {hs_intent_rd, hs_intent_wr, hs_strobe, hs_we, cpu_paused} = '0;
      hs_addr = '0; hs_wdata = '0;

      // write, burst read, drain
      v(5'b01000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h000, 8'h00);
      v(5'b01000, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h000, 8'h00);
      v(5'b01000, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h000, 8'h00);
      v(5'b01000, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h000, 8'h00);
      v(5'b01001, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h000, 8'h00);
      v(5'b01001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h000, 8'h00);
      v(5'b01001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h000, 8'h00);
      v(5'b01001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h000, 8'h00);
      v(5'b01001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h000, 8'h00);
      v(5'b01111, 12'h123, 8'hA5, 6'b111000, 8'h00, 12'h000, 8'h00);
      v(5'b01101, 12'h000, 8'hA5, 6'b111010, 8'h00, 12'h123, 8'hA5);
      v(5'b01101, 12'h001, 8'hA5, 6'b111000, 8'h00, 12'h000, 8'hA5);
      v(5'b01101, 12'h002, 8'hA5, 6'b111001, 8'h10, 12'h001, 8'hA5);
      v(5'b01101, 12'h003, 8'hA5, 6'b111001, 8'h11, 12'h002, 8'hA5);
      v(5'b00001, 12'h000, 8'h00, 6'b111001, 8'h12, 12'h003, 8'hA5);
      v(5'b00001, 12'h000, 8'h00, 6'b110001, 8'h13, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h003, 8'hA5);
      // pause bounce in SETTLE, then strobe on intent drop
      v(5'b10000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b10000, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b10000, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b10001, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b00111, 12'h055, 8'h3C, 6'b111000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b110000, 8'h00, 12'h003, 8'hA5);
      // intent dropped while waiting for pause
      v(5'b01000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b100000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h003, 8'hA5);
      v(5'b00000, 12'h000, 8'h00, 6'b000000, 8'h00, 12'h003, 8'hA5);

      @(negedge clk_sys);
      chk("reset_state", outs(), 64'd0);
      reset = 1'b0;

      foreach (tv[i]) begin
         @(negedge clk_sys);
         chk($sformatf("v%0d_flags", i),
             {58'd0, pause_req, ram_sel, hs_grant, hs_fail,
              ram_we, hs_rvalid}, {58'd0, tv[i].ef});
         chk($sformatf("v%0d_addr", i), {52'd0, ram_addr},
             {52'd0, tv[i].raddr});
         chk($sformatf("v%0d_din", i), {56'd0, ram_din},
             {56'd0, tv[i].rdin});
         if (tv[i].ef[0])
            chk($sformatf("v%0d_rdata", i), {56'd0, hs_rdata},
                {56'd0, tv[i].rdata});
         {hs_intent_rd, hs_intent_wr, hs_strobe, hs_we,
          cpu_paused} = tv[i].in_f;
         hs_addr  = tv[i].addr;
         hs_wdata = tv[i].wdata;
      end

      // timeout: pause never acknowledged
      @(negedge clk_sys);
      hs_intent_wr = 1'b1;
      rise = -1; failc = -1; nfail = 0; gseen = 0;
      preq_after = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         if (failc >= 0 && k == failc + 1) preq_after = pause_req;
         if (pause_req && rise < 0) rise = k;
         if (hs_grant) gseen = 1;
         if (hs_fail) begin
            nfail++;
            if (failc < 0) failc = k;
            hs_intent_wr = 1'b0;
         end
      end
      chk("tmo_preq_rise", 64'(rise), 64'd1);
      chk("tmo_fail_cycle", 64'(failc), 64'd21);
      chk("tmo_fail_count", 64'(nfail), 64'd1);
      chk("tmo_preq_after", {63'd0, preq_after}, 64'd0);
      chk("tmo_no_grant", 64'(gseen), 64'd0);

      // asynchronous reset mid-GRANT with ram_we high
      hs_intent_wr = 1'b1;
      cpu_paused   = 1'b1;
      n = 0;
      while (!hs_grant && n < 30) begin
         @(negedge clk_sys);
         n++;
      end
      chk("rst_grant_reached", {63'd0, hs_grant}, 64'd1);
      hs_strobe = 1'b1; hs_we = 1'b1;
      hs_addr = 12'h2AA; hs_wdata = 8'h5A;
      @(negedge clk_sys);
      hs_strobe = 1'b0; hs_we = 1'b0;
      chk("rst_pre_we", {63'd0, ram_we}, 64'd1);
      chk("rst_pre_addr", {52'd0, ram_addr}, 64'h2AA);
      reset = 1'b1;
      #1;
      chk("rst_async_outs", outs(), 64'd0);
      @(negedge clk_sys);
      hs_intent_wr = 1'b0;
      cpu_paused   = 1'b0;
      reset        = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_sys);
         chk($sformatf("post_rst_idle%0d", k), outs(), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
